// File: rtl/load_store_unit_if.sv
// Request/response and Memory bus bundle for load_store_unit.
// master = datapath + Memory side, slave = load_store_unit.
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    logic [WIDTH-1:0] mem_addr;
    logic             mem_cs;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_cs, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_cs, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word loads with extension, sub-word stores as RMW.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests take the error path instead of being masked.
//
// state | meaning
// IDLE  | ready for a request
// RD    | mem_cs_o high, Memory read of the containing word
// CAP   | capture read word; extract load lane or merge store lane
// WR    | mem_we_o high with full or merged word
// RESP  | one-cycle completion pulse
// ERR   | one-cycle completion pulse with error, no memory access
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP,
        S_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t state_q, state_d;

    logic             accept;
    logic             req_err;
    logic [1:0]       off_d;

    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic [WIDTH-1:0] wdata_q;

    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] load_ext;
    logic [WIDTH-1:0] merged;

    logic             mem_cs_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [WIDTH-1:0] resp_rdata_q;

    assign bus.req_ready = (state_q == S_IDLE);
    assign accept        = bus.req_valid && (state_q == S_IDLE);

    always_comb begin
        req_err = (bus.req_size == SZ_RSVD);
`ifdef MISALIGN_TRAP_EN
        if (bus.req_size == SZ_HALF && bus.req_addr[0])
            req_err = 1'b1;
        if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Low address bits that do not belong to the access size are dropped here.
    always_comb begin
        off_d = 2'b00;
        case (bus.req_size)
            SZ_BYTE: off_d = bus.req_addr[1:0];
            SZ_HALF: off_d = {bus.req_addr[1], 1'b0};
            default: off_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_d = S_ERR;
                    else if (bus.req_we && bus.req_size == SZ_WORD)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= off_d;
            wdata_q <= bus.req_wdata;
        end
    end

    // Lane extraction and merge; only consumed while in CAP.
    always_comb begin
        rd_byte  = bus.mem_rdata[{off_q, 3'b000} +: 8];
        rd_half  = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_ext = bus.mem_rdata;
        merged   = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                load_ext = uns_q ? {{(WIDTH-8){1'b0}}, rd_byte}
                                 : {{(WIDTH-8){rd_byte[7]}}, rd_byte};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_ext = uns_q ? {{(WIDTH-16){1'b0}}, rd_half}
                                 : {{(WIDTH-16){rd_half[15]}}, rd_half};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_ext = bus.mem_rdata;
                merged   = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            mem_cs_q     <= (state_d == S_RD);
            mem_we_q     <= (state_d == S_WR);
            resp_valid_q <= (state_d == S_RESP) || (state_d == S_ERR);
            resp_err_q   <= (state_d == S_ERR);
            resp_rdata_q <= '0;
            if (state_q == S_CAP && state_d == S_RESP)
                resp_rdata_q <= load_ext;
            if (accept)
                mem_addr_q <= {bus.req_addr[WIDTH-1:2], 2'b00};
            // Word stores go straight from IDLE with the request data.
            if (state_d == S_WR)
                mem_wdata_q <= (state_q == S_CAP) ? merged : bus.req_wdata;
        end
    end

    assign bus.mem_cs     = mem_cs_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a synchronous word Memory model.
module tb_load_store_unit;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk_i;
    logic rst_n_i;
    int   cyc;
    int   compared;
    int   mismatched;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] mem [0:63];
    logic [31:0] rd_q;
    logic        rd_v;
    int          we_cnt;
    int          cs_cnt;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory model: data valid only in the cycle after cs, garbage otherwise
    always @(posedge clk_i) begin
        rd_v <= bus.mem_cs;
        if (bus.mem_cs) begin
            rd_q   <= mem[bus.mem_addr[7:2]];
            cs_cnt <= cs_cnt + 1;
        end
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end
    assign bus.mem_rdata = rd_v ? rd_q : 32'hBADBAD00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (bus.mem_cs || bus.mem_we)
            chk("cs_we_exclusive", {31'b0, bus.mem_cs && bus.mem_we}, 32'd0);
        if (bus.resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_rdata"}, bus.resp_rdata, mon_e.rdata);
                chk({mon_e.name, "_err"}, {31'b0, bus.resp_err}, {31'b0, mon_e.err});
                chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input string nm, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] xr, input logic xe, input int xl,
                         input bit hold, output int acc);
        exp_t x;
        int   n;
        @(negedge clk_i);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        acc = cyc;
        if (!bus.req_ready) begin
            chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
            bus.req_valid = 1'b0;
        end else begin
            x.name  = nm;
            x.rdata = xr;
            x.err   = xe;
            x.lat   = xl;
            x.acc   = acc;
            sb_q.push_back(x);
            @(posedge clk_i);
            #1;
            if (!hold) bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk({nm, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n, we_b, cs_b;
        cyc        = 0;
        compared   = 0;
        mismatched = 0;
        we_cnt     = 0;
        cs_cnt     = 0;
        rd_v       = 1'b0;
        rd_q       = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n_i          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        repeat (3) @(negedge clk_i);
        chk("rst_ready",      {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_mem_cs",     {31'b0, bus.mem_cs},     32'd0);
        chk("rst_mem_we",     {31'b0, bus.mem_we},     32'd0);
        chk("rst_mem_addr",   bus.mem_addr,            32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,           32'd0);
        rst_n_i = 1'b1;

        // 1: word store / load
        issue("sw_10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, acc);
        issue("lw_10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, acc);
        drain("t1");

        // 2: byte store RMW and byte loads
        issue("sw_20", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, acc);
        drain("t2a");
        we_b = we_cnt;
        issue("sb_22", 1, 2'b00, 0, 32'h22, 32'h000000AA, 32'h0, 0, 4, 0, acc);
        drain("t2b");
        chk("sb_single_we", 32'(we_cnt - we_b), 32'd1);
        issue("lw_20a", 0, 2'b10, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 3, 0, acc);
        issue("lb_22",  0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFFAA, 0, 3, 0, acc);
        issue("lbu_22", 0, 2'b00, 1, 32'h22, 32'h0, 32'h000000AA, 0, 3, 0, acc);
        issue("lb_20",  0, 2'b00, 0, 32'h20, 32'h0, 32'h00000044, 0, 3, 0, acc);
        issue("lbu_23", 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000011, 0, 3, 0, acc);
        drain("t2c");

        // 3: half store RMW and half loads
        issue("sw_20b", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, acc);
        issue("sh_22",  1, 2'b01, 0, 32'h22, 32'h00008001, 32'h0, 0, 4, 0, acc);
        issue("lw_20b", 0, 2'b10, 0, 32'h20, 32'h0, 32'h80013344, 0, 3, 0, acc);
        issue("lh_22",  0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF8001, 0, 3, 0, acc);
        issue("lhu_22", 0, 2'b01, 1, 32'h22, 32'h0, 32'h00008001, 0, 3, 0, acc);
        issue("lh_20",  0, 2'b01, 0, 32'h20, 32'h0, 32'h00003344, 0, 3, 0, acc);
`ifdef MISALIGN_TRAP_EN
        issue("lh_21",  0, 2'b01, 0, 32'h21, 32'h0, 32'h0, 1, 1, 0, acc);
`else
        issue("lh_21",  0, 2'b01, 0, 32'h21, 32'h0, 32'h00003344, 0, 3, 0, acc);
`endif
        drain("t3");

        // 4: misaligned word load
        cs_b = cs_cnt;
`ifdef MISALIGN_TRAP_EN
        issue("lw_13", 0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, acc);
        drain("t4");
        chk("lw_13_no_cs", 32'(cs_cnt - cs_b), 32'd0);
`else
        issue("lw_13", 0, 2'b10, 0, 32'h13, 32'h0, 32'hDEADBEEF, 0, 3, 0, acc);
        drain("t4");
        chk("lw_13_one_cs", 32'(cs_cnt - cs_b), 32'd1);
`endif

        // 5: reset during the WR cycle of a byte store
        issue("sw_20c", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, acc);
        drain("t5a");
        we_b = we_cnt;
        issue("sb_21_rst", 1, 2'b00, 0, 32'h21, 32'h00000055, 32'h0, 0, 4, 0, acc);
        n = 0;
        while (!bus.mem_we && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_wr_reached", {31'b0, bus.mem_we}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        sb_q.delete();
        chk("rst_we_drop",    {31'b0, bus.mem_we},     32'd0);
        chk("rst_ready_mid",  {31'b0, bus.req_ready},  32'd1);
        chk("rst_no_resp",    {31'b0, bus.resp_valid}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        chk("rst_no_write", 32'(we_cnt - we_b), 32'd0);
        issue("lw_20_after_rst", 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, 3, 0, acc);
        drain("t5b");

        // 6: reserved size with valid held, then immediate next request
        cs_b = cs_cnt;
        we_b = we_cnt;
        issue("rsvd_20", 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1, 1, acc);
        issue("lw_20_b2b", 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, 3, 0, acc2);
        drain("t6");
        chk("b2b_gap", 32'(acc2 - acc), 32'd2);
        chk("rsvd_no_we", 32'(we_cnt - we_b), 32'd0);
        chk("rsvd_one_cs", 32'(cs_cnt - cs_b), 32'd1);

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
